// File: rtl/ir_sequencer.sv
// Instruction register, step counter and one-entry byte buffer in front of the control decoder.
// A decoder byte request with no buffered byte stalls the step sequence. A step-3 instruction traps.
`timescale 1ns/1ps
module ir_sequencer #(
  parameter int         COUNT_WIDTH = 16,
  parameter logic [7:0] RESET_IR    = 8'h00
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   data_in_select,
  input  logic                   rIR_enable,
  input  logic                   counter_clear,
  input  logic                   done,
  output logic [7:0]             bus_data,
  output logic [7:0]             rIR_data,
  output logic [1:0]             counter,
  output logic                   stall,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retired
);

  logic       r_buf_valid;
  logic [7:0] r_buf_data;

  logic w_need;
  logic w_stall;
  logic w_consume;
  logic w_accept;

  assign w_need    = rIR_enable | data_in_select;
  assign w_stall   = w_need & ~r_buf_valid;
  assign w_consume = w_need & r_buf_valid;
  assign w_accept  = in_valid & in_ready;

  assign stall    = w_stall;
  assign in_ready = ~r_buf_valid | w_consume;
  assign bus_data = r_buf_valid ? r_buf_data : 8'h00;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= 8'h00;
      rIR_data    <= RESET_IR;
      counter     <= 2'd0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      // Consume and accept in the same cycle keeps the buffer full at one byte per cycle.
      if (w_accept) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= in_data;
      end else if (w_consume) begin
        r_buf_valid <= 1'b0;
      end

      illegal <= 1'b0;
      if (!w_stall) begin
        if (counter == 2'd3) begin
          // No decoded instruction runs this long: abandon it and refetch.
          illegal  <= 1'b1;
          rIR_data <= RESET_IR;
          counter  <= 2'd0;
        end else begin
          if (rIR_enable) begin
            rIR_data <= bus_data;
          end
          counter <= counter_clear ? 2'd0 : counter + 2'd1;
          if (done && (retired != '1)) begin
            retired <= retired + COUNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule
